// File: rtl/instr_mem_ctrl_if.sv
// Handshake bundle between the instruction memory controller and its two masters:
// core fetch (read-only) and loader/debug (read/write).
interface instr_mem_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                      f_req_i;
   logic [ADDR_WIDTH-1:0]     f_addr_i;
   logic                      f_gnt_o;
   logic                      f_rvalid_o;
   logic [DATA_WIDTH-1:0]     f_rdata_o;

   logic                      l_req_i;
   logic [ADDR_WIDTH-1:0]     l_addr_i;
   logic                      l_we_i;
   logic [DATA_WIDTH/8-1:0]   l_be_i;
   logic [DATA_WIDTH-1:0]     l_wdata_i;
   logic                      l_gnt_o;
   logic                      l_rvalid_o;
   logic [DATA_WIDTH-1:0]     l_rdata_o;
   logic                      l_err_o;

   modport master (
      output f_req_i, f_addr_i,
      input  f_gnt_o, f_rvalid_o, f_rdata_o,
      output l_req_i, l_addr_i, l_we_i, l_be_i, l_wdata_i,
      input  l_gnt_o, l_rvalid_o, l_rdata_o, l_err_o
   );

   modport slave (
      input  f_req_i, f_addr_i,
      output f_gnt_o, f_rvalid_o, f_rdata_o,
      input  l_req_i, l_addr_i, l_we_i, l_be_i, l_wdata_i,
      output l_gnt_o, l_rvalid_o, l_rdata_o, l_err_o
   );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Dual-master instruction memory controller: word-interleaved single-port RAM banks plus
// a boot ROM, loader-priority arbitration and per-port response tag pipelines.
module instr_mem_ctrl #(
   parameter int unsigned RAM_SIZE       = 32768,
   parameter int unsigned NUM_BANKS      = 2,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = $clog2(RAM_SIZE) + 1,
   parameter int unsigned ROM_ADDR_WIDTH = 12,
   parameter int unsigned RD_LAT         = 1
) (
   input  logic             clk,
   input  logic             rst,
   instr_mem_ctrl_if.slave  bus
);

   localparam int unsigned BANK_BITS  = $clog2(NUM_BANKS);
   localparam int unsigned BANK_W     = (BANK_BITS == 0) ? 1 : BANK_BITS;
   localparam int unsigned BANK_WORDS = RAM_SIZE / 4 / NUM_BANKS;
   localparam int unsigned WORD_W     = $clog2(BANK_WORDS);
   localparam int unsigned ROM_IDX_W  = ROM_ADDR_WIDTH - 2;
   localparam int unsigned BE_W       = DATA_WIDTH / 8;

   typedef struct packed {
      logic              valid;
      logic              rom;
      logic [BANK_W-1:0] bank;
      logic              err;
      logic              we;
   } tag_t;

   function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
      if (NUM_BANKS == 1) return '0;
      return BANK_W'(a >> 2);
   endfunction

   // RAM region addresses wrap modulo RAM_SIZE: the MSB is excluded before indexing
   function automatic logic [WORD_W-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
      return WORD_W'(a[ADDR_WIDTH-2:0] >> (2 + BANK_BITS));
   endfunction

   function automatic logic rom_oor(input logic [ADDR_WIDTH-1:0] a);
      return (a[ADDR_WIDTH-2:0] >> ROM_ADDR_WIDTH) != '0;
   endfunction

   // Boot image: reset vector stub at word 0, remaining words carry their own index
   function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ROM_IDX_W-1:0] i);
      if (i == '0) return DATA_WIDTH'(32'h0000_0297);
      return DATA_WIDTH'(32'hB000_0000 | 32'(i));
   endfunction

   function automatic logic [DATA_WIDTH-1:0] pick(input tag_t t,
                                                  input logic [DATA_WIDTH-1:0] rom_d,
                                                  input logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] banks);
      if (!t.valid || t.we || t.err) return '0;
      if (t.rom) return rom_d;
      return banks[t.bank];
   endfunction

   logic                 f_is_rom, l_is_rom, conflict_c;
   logic                 f_gnt, l_gnt;
   logic [BANK_W-1:0]    f_bank, l_bank;
   logic [WORD_W-1:0]    f_word, l_word;

   // Address decode and loader-priority arbitration
   always_comb begin
      f_is_rom   = bus.f_addr_i[ADDR_WIDTH-1];
      l_is_rom   = bus.l_addr_i[ADDR_WIDTH-1];
      f_bank     = bank_of(bus.f_addr_i);
      l_bank     = bank_of(bus.l_addr_i);
      f_word     = word_of(bus.f_addr_i);
      l_word     = word_of(bus.l_addr_i);
      conflict_c = bus.l_req_i &&
                   ((l_is_rom && f_is_rom) || (!l_is_rom && !f_is_rom && (l_bank == f_bank)));
      l_gnt      = bus.l_req_i && !rst;
      f_gnt      = bus.f_req_i && !rst && !conflict_c;
   end

   assign bus.l_gnt_o = l_gnt;
   assign bus.f_gnt_o = f_gnt;

   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rd;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [BANK_WORDS];
      logic [DATA_WIDTH-1:0] rdq;
      logic                  l_sel, f_sel, wr_en, rd_en;
      logic [WORD_W-1:0]     idx;

      always_comb begin
         l_sel = l_gnt && !l_is_rom && (l_bank == BANK_W'(b));
         f_sel = f_gnt && !f_is_rom && (f_bank == BANK_W'(b));
         idx   = l_sel ? l_word : f_word;
         wr_en = l_sel && bus.l_we_i;
         rd_en = (l_sel && !bus.l_we_i) || (!l_sel && f_sel);
      end

      always_ff @(posedge clk) begin
         if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
               if (bus.l_be_i[i]) mem[idx][8*i +: 8] <= bus.l_wdata_i[8*i +: 8];
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst)        rdq <= '0;
         else if (rd_en) rdq <= mem[idx];
      end

      assign bank_rd[b] = rdq;
   end

   logic                  rom_rd;
   logic [ROM_IDX_W-1:0]  rom_idx;
   logic [DATA_WIDTH-1:0] rom_q;

   // ROM is single-ported; loader writes to it never touch the array
   always_comb begin
      rom_rd  = (l_gnt && l_is_rom && !bus.l_we_i) || (f_gnt && f_is_rom);
      rom_idx = (l_gnt && l_is_rom) ? ROM_IDX_W'(bus.l_addr_i >> 2) : ROM_IDX_W'(bus.f_addr_i >> 2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         rom_q <= '0;
      else if (rom_rd) rom_q <= rom_word(rom_idx);
   end

   tag_t f_tag_c, l_tag_c, f_tag1, l_tag1;

   always_comb begin
      f_tag_c = '0;
      l_tag_c = '0;
      if (f_gnt) begin
         f_tag_c.valid = 1'b1;
         f_tag_c.rom   = f_is_rom;
         f_tag_c.bank  = f_bank;
         f_tag_c.err   = f_is_rom && rom_oor(bus.f_addr_i);
      end
      if (l_gnt) begin
         l_tag_c.valid = 1'b1;
         l_tag_c.rom   = l_is_rom;
         l_tag_c.bank  = l_bank;
         l_tag_c.we    = bus.l_we_i;
         l_tag_c.err   = l_is_rom && (bus.l_we_i || rom_oor(bus.l_addr_i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_tag1 <= '0;
         l_tag1 <= '0;
      end else begin
         f_tag1 <= f_tag_c;
         l_tag1 <= l_tag_c;
      end
   end

   logic [DATA_WIDTH-1:0] f_data1_c, l_data1_c;
   logic                  l_err1_c;

   // Read data is steered by the in-flight tag, never by the current request address
   always_comb begin
      f_data1_c = pick(f_tag1, rom_q, bank_rd);
      l_data1_c = pick(l_tag1, rom_q, bank_rd);
      l_err1_c  = l_tag1.valid && l_tag1.err;
   end

   if (RD_LAT == 2) begin : g_lat2
      logic                  f_v2, l_v2, l_e2;
      logic [DATA_WIDTH-1:0] f_d2, l_d2;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            f_v2 <= 1'b0;
            l_v2 <= 1'b0;
            l_e2 <= 1'b0;
            f_d2 <= '0;
            l_d2 <= '0;
         end else begin
            f_v2 <= f_tag1.valid;
            l_v2 <= l_tag1.valid;
            l_e2 <= l_err1_c;
            f_d2 <= f_data1_c;
            l_d2 <= l_data1_c;
         end
      end

      assign bus.f_rvalid_o = f_v2;
      assign bus.f_rdata_o  = f_d2;
      assign bus.l_rvalid_o = l_v2;
      assign bus.l_rdata_o  = l_d2;
      assign bus.l_err_o    = l_e2;
   end else begin : g_lat1
      assign bus.f_rvalid_o = f_tag1.valid;
      assign bus.f_rdata_o  = f_data1_c;
      assign bus.l_rvalid_o = l_tag1.valid;
      assign bus.l_rdata_o  = l_data1_c;
      assign bus.l_err_o    = l_err1_c;
   end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: one RD_LAT=1 and one RD_LAT=2 instance driven in lockstep.
module tb_instr_mem_ctrl;

   localparam int unsigned AW       = 16;
   localparam int unsigned DW       = 32;
   localparam int unsigned RAM_SIZE = 32768;
   localparam int unsigned ROM_AW   = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instr_mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
   instr_mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

   instr_mem_ctrl #(.RAM_SIZE(RAM_SIZE), .NUM_BANKS(2), .ROM_ADDR_WIDTH(ROM_AW), .RD_LAT(1))
      u_lat1 (.clk(clk), .rst(rst), .bus(bus1));
   instr_mem_ctrl #(.RAM_SIZE(RAM_SIZE), .NUM_BANKS(2), .ROM_ADDR_WIDTH(ROM_AW), .RD_LAT(2))
      u_lat2 (.clk(clk), .rst(rst), .bus(bus2));

   typedef struct {
      int          sid;   // instance*2 + port (port 0 fetch, 1 loader)
      int          due;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ram_m [RAM_SIZE/4];
   int          cyc    = 0;
   int          n_chk  = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Reference behaviour, expressed on flat byte addresses
   function automatic int ram_idx(input logic [AW-1:0] a);
      return int'((a % AW'(RAM_SIZE)) / 4);
   endfunction

   function automatic logic rom_bad(input logic [AW-1:0] a);
      logic [AW-1:0] off;
      off = a & AW'(RAM_SIZE - 1);
      return off >= AW'(1 << ROM_AW);
   endfunction

   function automatic logic [31:0] rom_model(input logic [AW-1:0] a);
      int w;
      if (rom_bad(a)) return 32'h0;
      w = int'((a % AW'(1 << ROM_AW)) / 4);
      if (w == 0) return 32'h0000_0297;
      return 32'hB000_0000 + 32'(w);
   endfunction

   function automatic logic same_res(input logic [AW-1:0] a, input logic [AW-1:0] b);
      if (a[AW-1] != b[AW-1]) return 1'b0;
      if (a[AW-1]) return 1'b1;
      return (ram_idx(a) % 2) == (ram_idx(b) % 2);
   endfunction

   task automatic push(input int port, input logic [31:0] d, input logic e);
      for (int k = 0; k < 2; k++) begin
         exp_t x;
         x.sid  = k*2 + port;
         x.due  = cyc + k + 1;
         x.data = d;
         x.err  = e;
         sb.push_back(x);
      end
   endtask

   task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic lr,
                        input logic [AW-1:0] la, input logic lwe, input logic [3:0] lbe,
                        input logic [31:0] lwd);
      bus1.f_req_i = fr;  bus1.f_addr_i = fa;
      bus1.l_req_i = lr;  bus1.l_addr_i = la; bus1.l_we_i = lwe;
      bus1.l_be_i  = lbe; bus1.l_wdata_i = lwd;
      bus2.f_req_i = fr;  bus2.f_addr_i = fa;
      bus2.l_req_i = lr;  bus2.l_addr_i = la; bus2.l_we_i = lwe;
      bus2.l_be_i  = lbe; bus2.l_wdata_i = lwd;
   endtask

   // One bus cycle: drive, check grants mid-cycle, queue expected responses
   task automatic do_cycle(input logic fr, input logic [AW-1:0] fa, input logic lr,
                           input logic [AW-1:0] la, input logic lwe, input logic [3:0] lbe,
                           input logic [31:0] lwd, output logic fg);
      logic        exp_lg, exp_fg, le;
      logic [31:0] ld, fd;
      int          w;
      drive(fr, fa, lr, la, lwe, lbe, lwd);
      @(negedge clk);
      exp_lg = lr && !rst;
      exp_fg = fr && !rst && !(lr && same_res(fa, la));
      chk("l_gnt_lat1", 32'(bus1.l_gnt_o), 32'(exp_lg));
      chk("f_gnt_lat1", 32'(bus1.f_gnt_o), 32'(exp_fg));
      chk("l_gnt_lat2", 32'(bus2.l_gnt_o), 32'(exp_lg));
      chk("f_gnt_lat2", 32'(bus2.f_gnt_o), 32'(exp_fg));
      fg = exp_fg;
      if (exp_lg) begin
         ld = 32'h0;
         le = 1'b0;
         if (la[AW-1]) begin
            le = lwe || rom_bad(la);
            if (!lwe) ld = rom_model(la);
         end else begin
            w = ram_idx(la);
            if (lwe) begin
               for (int b = 0; b < 4; b++) if (lbe[b]) ram_m[w][8*b +: 8] = lwd[8*b +: 8];
            end else begin
               ld = ram_m[w];
            end
         end
         push(1, ld, le);
      end
      if (exp_fg) begin
         fd = fa[AW-1] ? rom_model(fa) : ram_m[ram_idx(fa)];
         push(0, fd, 1'b0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      drive(1'b0, '0, 1'b0, '0, 1'b0, 4'h0, 32'h0);
      @(negedge clk);
      #1 rst = 1'b1;
      sb.delete();
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic mon_port(input int sid, input string nm, input logic v,
                           input logic [31:0] d, input logic e, input logic has_err);
      int idx;
      idx = -1;
      if (!v) return;
      foreach (sb[i]) if (idx < 0 && sb[i].sid == sid) idx = i;
      if (idx < 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_unexpected_rvalid @cycle %0d: got rvalid=1 expected none pending", nm, cyc);
         return;
      end
      chk({nm, "_latency"}, 32'(cyc), 32'(sb[idx].due));
      chk({nm, "_rdata"}, d, sb[idx].data);
      if (has_err) chk({nm, "_err"}, 32'(e), 32'(sb[idx].err));
      sb.delete(idx);
   endtask

   // Response monitor: decoupled from stimulus, samples mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("reset_state_lat1",
                {25'h0, bus1.f_gnt_o, bus1.f_rvalid_o, bus1.l_gnt_o, bus1.l_rvalid_o,
                 bus1.l_err_o, |bus1.f_rdata_o, |bus1.l_rdata_o}, 32'h0);
            chk("reset_state_lat2",
                {25'h0, bus2.f_gnt_o, bus2.f_rvalid_o, bus2.l_gnt_o, bus2.l_rvalid_o,
                 bus2.l_err_o, |bus2.f_rdata_o, |bus2.l_rdata_o}, 32'h0);
         end else begin
            mon_port(0, "f_lat1", bus1.f_rvalid_o, bus1.f_rdata_o, 1'b0, 1'b0);
            mon_port(1, "l_lat1", bus1.l_rvalid_o, bus1.l_rdata_o, bus1.l_err_o, 1'b1);
            mon_port(2, "f_lat2", bus2.f_rvalid_o, bus2.f_rdata_o, 1'b0, 1'b0);
            mon_port(3, "l_lat2", bus2.l_rvalid_o, bus2.l_rdata_o, bus2.l_err_o, 1'b1);
            for (int i = sb.size() - 1; i >= 0; i--) begin
               if (sb[i].due <= cyc) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL missing_rvalid stream %0d @cycle %0d: got no rvalid expected one due at %0d",
                           sb[i].sid, cyc, sb[i].due);
                  sb.delete(i);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test expected completion before time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [AW-1:0] rand_addr();
      int          r;
      logic [AW-1:0] a;
      r = int'($urandom_range(0, 99));
      if (r < 25) begin
         a = AW'(16'h8000) | AW'($urandom_range(0, 1023) * 4);
         if (r < 5) a = a | AW'(16'h2000);
      end else begin
         a = AW'($urandom_range(0, 63) * 4);
      end
      return a;
   endfunction

   initial begin
      logic          fg, cur_fr, lr, lwe;
      logic [AW-1:0] cur_fa;
      logic [AW-1:0] a6;

      drive(1'b0, '0, 1'b0, '0, 1'b0, 4'h0, 32'h0);
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Boot fetch of ROM word 0
      do_cycle(1'b1, 16'h8000, 1'b0, '0, 1'b0, 4'h0, 32'h0, fg);

      // Initialise the RAM window used below
      for (int i = 0; i < 64; i++)
         do_cycle(1'b0, '0, 1'b1, AW'(i*4), 1'b1, 4'hF, $urandom, fg);

      // Full-word write then byte-masked overwrite, fetched back
      do_cycle(1'b0, '0, 1'b1, 16'h0004, 1'b1, 4'hF, 32'hDEADBEEF, fg);
      do_cycle(1'b0, '0, 1'b1, 16'h0004, 1'b1, 4'h1, 32'h0000_00AA, fg);
      do_cycle(1'b1, 16'h0004, 1'b0, '0, 1'b0, 4'h0, 32'h0, fg);

      // Parallel access on different banks, then a same-bank conflict with a held fetch
      do_cycle(1'b1, 16'h0004, 1'b1, 16'h0000, 1'b0, 4'h0, 32'h0, fg);
      do_cycle(1'b1, 16'h0008, 1'b1, 16'h0008, 1'b0, 4'h0, 32'h0, fg);
      do_cycle(1'b1, 16'h0008, 1'b0, '0, 1'b0, 4'h0, 32'h0, fg);

      // ROM write error, ROM readback, out-of-range ROM read, wrap-edge RAM word
      do_cycle(1'b0, '0, 1'b1, 16'h8010, 1'b1, 4'hF, 32'h1234_5678, fg);
      do_cycle(1'b1, 16'h8010, 1'b0, '0, 1'b0, 4'h0, 32'h0, fg);
      do_cycle(1'b0, '0, 1'b1, 16'h8010, 1'b0, 4'h0, 32'h0, fg);
      do_cycle(1'b1, 16'h9000, 1'b1, 16'hA004, 1'b0, 4'h0, 32'h0, fg);
      do_cycle(1'b1, 16'h9000, 1'b0, '0, 1'b0, 4'h0, 32'h0, fg);
      do_cycle(1'b0, '0, 1'b1, 16'h7FFC, 1'b1, 4'hF, 32'hCAFE_F00D, fg);
      do_cycle(1'b1, 16'h7FFC, 1'b1, 16'h7FF8, 1'b0, 4'h0, 32'h0, fg);

      // Back-to-back ROM/RAM fetches with reset pulsed after the fifth grant
      for (int i = 0; i < 8; i++) begin
         a6 = AW'(i*4) | ((i % 2 == 1) ? AW'(16'h8000) : AW'(0));
         do_cycle(1'b1, a6, 1'b0, '0, 1'b0, 4'h0, 32'h0, fg);
         if (i == 4) pulse_reset();
      end

      // Randomised traffic; a stalled fetch keeps its request and address
      cur_fr = 1'b0;
      cur_fa = '0;
      for (int n = 0; n < 400; n++) begin
         if (!cur_fr || fg) begin
            cur_fr = ($urandom_range(0, 3) != 0);
            cur_fa = rand_addr();
         end
         lr  = ($urandom_range(0, 1) == 1);
         lwe = ($urandom_range(0, 1) == 1);
         do_cycle(cur_fr, cur_fa, lr, rand_addr(), lwe, 4'($urandom_range(0, 15)), $urandom, fg);
      end

      for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, 1'b0, '0, 1'b0, 4'h0, 32'h0, fg);
      chk("scoreboard_drain", 32'(sb.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Parametrised instruction-memory controller. It replaces the single-port boot-ROM/RAM wrapper on the core instruction side and serves two masters:
- the core fetch port (read-only, req/gnt/rvalid handshake);
- the loader/debug port (read/write, same handshake).

Instruction RAM is split into NUM_BANKS word-interleaved single-port banks, so both ports proceed in parallel when they hit different banks. An in-flight tag pipeline steers read data correctly for a configurable latency.

Parameters:
RAM_SIZE, 32768, instruction RAM size in bytes (all banks combined)
NUM_BANKS, 2, RAM bank count; power of 2, 1..8
DATA_WIDTH, 32, word width; only 32 supported
ADDR_WIDTH, $clog2(RAM_SIZE)+1, byte address width; MSB=1 selects boot ROM
ROM_ADDR_WIDTH, 12, boot ROM byte-address width
RD_LAT, 1, read latency in cycles (1 or 2; 2 adds an output register stage)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
f_req_i  in  1  fetch request
f_addr_i  in  ADDR_WIDTH  fetch byte address, word aligned
f_gnt_o  out  1  fetch request accepted this cycle
f_rvalid_o  out  1  fetch read data valid
f_rdata_o  out  DATA_WIDTH  fetch read data
l_req_i  in  1  loader request
l_addr_i  in  ADDR_WIDTH  loader byte address
l_we_i  in  1  loader write enable
l_be_i  in  DATA_WIDTH/8  loader byte enables
l_wdata_i  in  DATA_WIDTH  loader write data
l_gnt_o  out  1  loader request accepted
l_rvalid_o  out  1  loader response valid (reads and writes)
l_rdata_o  out  DATA_WIDTH  loader read data (0 for writes)
l_err_o  out  1  with l_rvalid_o: write to ROM region or ROM address beyond ROM_ADDR_WIDTH

Behaviour:
- Reset: all gnt/rvalid/err outputs 0; rdata outputs 0; tag pipelines cleared. Reset mid-operation drops in-flight responses, with no rvalid after release.
- Region decode: addr[ADDR_WIDTH-1]=1 selects ROM, otherwise RAM.
- RAM bank = addr[2 +: log2(NUM_BANKS)]. Bank word index = remaining upper bits below the MSB.
- Grant is combinational from req and address in the same cycle.
  - Loader is always granted unless rst is asserted.
  - Fetch is granted unless it targets the same resource (same RAM bank, or ROM) as a loader request that cycle. Loader has fixed priority.
- Fetch stalled by a conflict: f_gnt_o=0. The master holds req/addr stable; no state is kept inside.
- Both ports on different resources in one cycle: both granted, both serviced in parallel.
- Each granted request pushes a tag {valid, region, bank, err} into a per-port RD_LAT-deep shift register.
  - rvalid_o = tag valid at stage RD_LAT.
  - rdata muxes the bank/ROM output selected by the tag, never by the current address.
- Exactly one rvalid per gnt, in order. Latency is exactly RD_LAT cycles after the gnt edge. Back-to-back requests give one response per cycle, with no bubbles.
- Loader write: bank write with l_be_i masks. Response carries l_rdata_o=0.
- Write to ROM region: no memory change; l_err_o=1 with the rvalid.
- ROM read with address bits between ROM_ADDR_WIDTH and MSB non-zero: returns 0; l_err_o=1 (loader only; fetch returns 0, no error output).
- Read-after-write, same bank, consecutive cycles: the read returns the new data (bank is write-first or sequenced; no hazard).
- Address wrap: byte addresses wrap modulo RAM_SIZE within the RAM region; no overflow into ROM.
- NUM_BANKS=1: every simultaneous RAM/RAM pair conflicts; loader wins.

Test Plan:
1. Reset release, then fetch of 0x8000_0000 region (MSB=1, ROM word 0 = 0x0000_0297), RD_LAT=1 -> f_gnt_o=1 at cycle 0, f_rvalid_o=1 with 0x0000_0297 at cycle 1.
2. Loader writes 0xDEADBEEF to 0x0004 (be=4'b1111), then 0x0000_00AA to 0x0004 (be=4'b0001); fetch 0x0004 -> rdata 0xDEADBEAA; l_rvalid/l_err = 1/0 per write.
3. NUM_BANKS=2, same cycle: loader reads 0x0000 (bank 0) and fetch reads 0x0004 (bank 1) -> both gnt=1, both rvalid next cycle with correct data.
4. Same cycle, both on 0x0008 (bank 0) -> l_gnt=1, f_gnt=0. Fetch held: granted the next cycle, response one cycle later.
5. Loader write to ROM address 0x8000_0010 -> l_rvalid=1, l_err=1; subsequent ROM read unchanged.
6. RD_LAT=2, 8 back-to-back fetches 0x0000..0x001C, alternating ROM/RAM, with rst pulsed after the 5th gnt -> first 4 responses in order at gnt+2; no rvalid after reset release until new gnts.
